// File: rtl/debounce_pkg.sv
// Shared definitions for the pushbutton debouncer: FSM state encoding and
// default qualification length.
package debounce_pkg;

   typedef enum logic [1:0] {
      ST_STABLE_LO = 2'b00,
      ST_CHECK_HI  = 2'b01,
      ST_STABLE_HI = 2'b11,
      ST_CHECK_LO  = 2'b10
   } state_e;

   localparam int DEBOUNCE_CYCLES_DEF = 4;
   localparam int CNT_WIDTH_DEF       = 3;

   function automatic logic is_check(input state_e s);
      return (s == ST_CHECK_HI) || (s == ST_CHECK_LO);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both stages reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/button_debouncer.sv
// Pushbutton conditioner: synchronizes a bouncy raw input, accepts a new level
// only after DEBOUNCE_CYCLES identical samples, and flags each accepted edge.
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic btn_level,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                 btn_sync;
   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 level_q, level_d;
   logic                 rise_q, rise_d;
   logic                 fall_q, fall_d;
   logic                 busy_q, busy_d;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (btn_in),
      .q_o   (btn_sync)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_STABLE_LO;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   // Terminal compare is checked before incrementing, and every state exit
   // clears the counter, so it can never wrap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_STABLE_LO: begin
            if (btn_sync) begin
               state_d = ST_CHECK_HI;
               cnt_d   = CNT_ONE;
            end
         end
         ST_CHECK_HI: begin
            if (!btn_sync) begin
               state_d = ST_STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_STABLE_HI;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_STABLE_HI: begin
            if (!btn_sync) begin
               state_d = ST_CHECK_LO;
               cnt_d   = CNT_ONE;
            end
         end
         ST_CHECK_LO: begin
            if (btn_sync) begin
               state_d = ST_STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_STABLE_LO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   // Pulses fire only on a completed qualification, never on an abort.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      busy_d  = is_check(state_d);
      if ((state_q == ST_CHECK_HI) && (state_d == ST_STABLE_HI)) begin
         level_d = 1'b1;
         rise_d  = 1'b1;
      end
      if ((state_q == ST_CHECK_LO) && (state_d == ST_STABLE_LO)) begin
         level_d = 1'b0;
         fall_d  = 1'b1;
      end
   end

   assign btn_level  = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: table of per-cycle vectors fed through a
// scoreboard queue, plus hand-written reset sequences.
module tb_button_debouncer;

   logic       clk;
   logic       rst_n;
   logic       btn_in;
   logic       btn_level;
   logic       rise_pulse;
   logic       fall_pulse;
   logic       busy;
   logic [3:0] dut_out;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected output word: {btn_level, rise_pulse, fall_pulse, busy}
   logic [3:0] exp_q[$];

   typedef struct {
      logic       btn;
      logic [3:0] exp;
      int         reps;
   } vec_t;

   vec_t vecs[$];

   button_debouncer #(
      .DEBOUNCE_CYCLES (4),
      .CNT_WIDTH       (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_in     (btn_in),
      .btn_level  (btn_level),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .busy       (busy)
   );

   assign dut_out = {btn_level, rise_pulse, fall_pulse, busy};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b (level,rise,fall,busy) at %0t", name, act, exp, $time);
      end
   endtask

   // Called with clk low: drive, push expectation, sample after the edge.
   task automatic step(input logic b, input logic [3:0] e, input string name);
      logic [3:0] want;
      btn_in = b;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      check(name, dut_out, want);
      @(negedge clk);
   endtask

   initial begin
      rst_n  = 1'b1;
      btn_in = 1'b0;

      // idle, press, release, bouncy press, release, glitch low-side,
      // press, glitch high-side, abort at terminal count then release
      vecs.push_back('{1'b0, 4'b0000, 4});
      vecs.push_back('{1'b1, 4'b0000, 2});
      vecs.push_back('{1'b1, 4'b0001, 3});
      vecs.push_back('{1'b1, 4'b1100, 1});
      vecs.push_back('{1'b1, 4'b1000, 3});
      vecs.push_back('{1'b0, 4'b1000, 2});
      vecs.push_back('{1'b0, 4'b1001, 3});
      vecs.push_back('{1'b0, 4'b0010, 1});
      vecs.push_back('{1'b0, 4'b0000, 3});
      vecs.push_back('{1'b1, 4'b0000, 1});
      vecs.push_back('{1'b0, 4'b0000, 1});
      vecs.push_back('{1'b1, 4'b0001, 1});
      vecs.push_back('{1'b0, 4'b0000, 1});
      vecs.push_back('{1'b1, 4'b0001, 1});
      vecs.push_back('{1'b1, 4'b0000, 1});
      vecs.push_back('{1'b1, 4'b0001, 3});
      vecs.push_back('{1'b1, 4'b1100, 1});
      vecs.push_back('{1'b1, 4'b1000, 3});
      vecs.push_back('{1'b0, 4'b1000, 2});
      vecs.push_back('{1'b0, 4'b1001, 3});
      vecs.push_back('{1'b0, 4'b0010, 1});
      vecs.push_back('{1'b0, 4'b0000, 3});
      vecs.push_back('{1'b1, 4'b0000, 1});
      vecs.push_back('{1'b0, 4'b0000, 1});
      vecs.push_back('{1'b0, 4'b0001, 1});
      vecs.push_back('{1'b0, 4'b0000, 4});
      vecs.push_back('{1'b1, 4'b0000, 2});
      vecs.push_back('{1'b1, 4'b0001, 3});
      vecs.push_back('{1'b1, 4'b1100, 1});
      vecs.push_back('{1'b1, 4'b1000, 3});
      vecs.push_back('{1'b0, 4'b1000, 1});
      vecs.push_back('{1'b1, 4'b1000, 1});
      vecs.push_back('{1'b1, 4'b1001, 1});
      vecs.push_back('{1'b1, 4'b1000, 3});
      vecs.push_back('{1'b0, 4'b1000, 2});
      vecs.push_back('{1'b0, 4'b1001, 1});
      vecs.push_back('{1'b1, 4'b1001, 1});
      vecs.push_back('{1'b0, 4'b1001, 1});
      vecs.push_back('{1'b0, 4'b1000, 1});
      vecs.push_back('{1'b0, 4'b1001, 3});
      vecs.push_back('{1'b0, 4'b0010, 1});
      vecs.push_back('{1'b0, 4'b0000, 4});

      // Power-up reset, asynchronous assertion
      #1 rst_n = 1'b0;
      #1 check("rst_async", dut_out, 4'b0000);
      repeat (3) begin
         @(posedge clk);
         #1 check("rst_hold", dut_out, 4'b0000);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) step(1'b0, 4'b0000, "idle");

      for (int i = 0; i < vecs.size(); i++) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            step(vecs[i].btn, vecs[i].exp, $sformatf("tbl%0d_%0d", i, r));
         end
      end

      // Reset two cycles after busy rises
      repeat (2) step(1'b1, 4'b0000, "mq_sync");
      repeat (3) step(1'b1, 4'b0001, "mq_busy");
      rst_n = 1'b0;
      #1 check("mq_rst_async", dut_out, 4'b0000);
      repeat (2) begin
         @(posedge clk);
         #1 check("mq_rst_hold", dut_out, 4'b0000);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Input high at release: full qualification and a rise pulse
      repeat (2) step(1'b1, 4'b0000, "rel_sync");
      repeat (3) step(1'b1, 4'b0001, "rel_busy");
      step(1'b1, 4'b1100, "rel_rise");

      // Reset while the rise pulse is showing
      rst_n = 1'b0;
      #1 check("mp_rst_async", dut_out, 4'b0000);
      repeat (2) begin
         @(posedge clk);
         #1 check("mp_rst_hold", dut_out, 4'b0000);
      end
      @(negedge clk);
      btn_in = 1'b0;
      rst_n  = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b0, 4'b0000, "mp_after");

      check("sb_drained", 4'(exp_q.size()), 4'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions a raw, asynchronous, bouncy pushbutton/switch into a clean, synchronous, debounced level plus one-cycle edge pulses.
- Sits directly upstream of the inverter stage: btn_level drives the inverter's input `a`.
- Removes metastability and bounce, so downstream gates only ever see a stable, glitch-free value.

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive identical synchronized samples required to accept a new level; legal range is 2 or more.
- CNT_WIDTH, 3, width of the stability counter; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_in  input  1  raw button input; asynchronous to clk and may bounce.
- btn_level  output  1  debounced level, registered.
- rise_pulse  output  1  one-cycle pulse when btn_level goes 0->1.
- fall_pulse  output  1  one-cycle pulse when btn_level goes 1->0.
- busy  output  1  high while a candidate change is being qualified (CHECK_HI or CHECK_LO).

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - Clears both synchronizer flops, the FSM (to STABLE_LO) and the counter.
  - btn_level=0, rise_pulse=0, fall_pulse=0, busy=0.
  - Release is sampled on a clk rising edge.
- Synchronizer: two flops in series, btn_in -> s1 -> s2. The FSM sees s2 only.
- FSM states: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
  - STABLE_LO: s2=1 -> CHECK_HI, cnt<=1. Otherwise hold.
  - CHECK_HI:
    - s2=0 -> STABLE_LO, cnt<=0 (bounce rejected, no pulse).
    - s2=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, btn_level<=1, rise_pulse<=1, cnt<=0.
    - s2=1 otherwise -> cnt<=cnt+1.
  - STABLE_HI and CHECK_LO: mirror image of the two states above, with fall_pulse and btn_level<=0.
- Latency: if raw btn_in is first captured into s1 at edge k and stays stable, btn_level changes after edge k+DEBOUNCE_CYCLES+1. With the default of 4, that is edge k+5.
- Pulses:
  - Registered; high for exactly one cycle, the cycle in which btn_level first shows its new value.
  - Never both high in the same cycle.
  - Deasserted on the next edge unconditionally.
- busy is a registered decode of the next state: high exactly while the FSM is in CHECK_HI or CHECK_LO.
- Any single opposite s2 sample during a CHECK state aborts qualification. The counter restarts from 1 on the next qualifying sample.
- A pulse on btn_in shorter than one clk period may be missed entirely; this is acceptable.
- The counter never wraps: it is cleared on every state exit and the terminal compare precedes the increment.
- Reset asserted mid-qualification or mid-pulse: outputs go to reset values immediately; no pulse is emitted after reset is released.
- If btn_in is high when reset is released: a normal rise is qualified and a rise_pulse is emitted. There is no silent power-up adoption.

Decomposition:
- Shared package/include debounce_pkg:
  - 2-bit state encoding constants ST_STABLE_LO=00, ST_CHECK_HI=01, ST_STABLE_HI=11, ST_CHECK_LO=10.
  - Default DEBOUNCE_CYCLES.
- One natural sub-module: sync_2ff (1-bit, clk/rst_n, two-flop synchronizer with reset value 0). Reusable by other input stages.
- FSM, counter and output registers live in button_debouncer.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, btn_in=0, release -> btn_level=0, rise_pulse=0, fall_pulse=0, busy=0 for 20 cycles.
- Clean press (DEBOUNCE_CYCLES=4): btn_in 0->1 captured at edge 10 and held -> busy high after edges 12-14; btn_level=1 and rise_pulse=1 after edge 15 only; rise_pulse=0 after edge 16.
- Bouncy press: btn_in toggles 1,0,1,0 on successive cycles, then holds 1 -> no pulse during bounce; exactly one rise_pulse, 5 cycles after the last 0->1 capture.
- Clean release from high: btn_in 1->0 held -> exactly one fall_pulse, btn_level=0, same 5-cycle latency; rise_pulse stays 0.
- Reset mid-qualification: btn_in=1, assert rst_n=0 two cycles after busy rises -> outputs 0 immediately (asynchronous). After release, a fresh 5-cycle qualification then rise_pulse.
- Glitch rejection: a 1-cycle-wide high on btn_in while STABLE_LO -> busy pulses for at most 1 cycle; btn_level stays 0; no rise_pulse or fall_pulse.
